vend_txn_controller: RTL and testbench

Transaction sequencer for the vending machine datapath. It accumulates coin credit and validates product selections against price and stock. It drives a req/ack handshake to the product dispenser, then returns change as 5-unit coin pulses. It also handles cancel and inactivity-timeout refunds.

---
 rtl/vend_txn_controller.sv | 217 +++++++++++++++++++++
 tb/tb_vend_txn_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: coin credit, selection checks, dispenser
// handshake and 5-unit change payout with cancel and inactivity refunds.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no credit held, waiting for the first coin
// COLLECT | credit > 0, accepting coins/selections, timeout running
// VEND    | disp_req held until the dispenser acknowledges
// CHANGE  | one 5-unit change pulse per cycle until credit is zero
module vend_txn_controller #(
  parameter int          PRICE_NEWS  = 5,
  parameter int          PRICE_CHOC  = 10,
  parameter int          PRICE_JUICE = 15,
  parameter logic [3:0]  STOCK_INIT  = 4'd3,
  parameter int          MAX_CREDIT  = 30,
  parameter int          TIMEOUT     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [4:0] coin_value,
  input  logic       select_valid,
  input  logic [1:0] select_product,
  input  logic       cancel,
  input  logic       disp_ack,
  output logic       disp_req,
  output logic [1:0] disp_product,
  output logic       change_pulse,
  output logic [4:0] balance,
  output logic       busy,
  output logic       coin_reject,
  output logic       err_valid,
  output logic [1:0] err_code,
  output logic [2:0] sold_out
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  localparam logic [4:0] P_NEWS   = 5'(PRICE_NEWS);
  localparam logic [4:0] P_CHOC   = 5'(PRICE_CHOC);
  localparam logic [4:0] P_JUICE  = 5'(PRICE_JUICE);
  localparam logic [5:0] MAX_C    = 6'(MAX_CREDIT);
  localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 1);
  localparam logic [4:0] COIN_UNIT = 5'd5;

  localparam logic [1:0] ERR_CREDIT  = 2'd1;
  localparam logic [1:0] ERR_SOLDOUT = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

  state_t      state, next_state;
  logic [4:0]  credit, credit_nxt;
  logic [4:0]  tmo_cnt, tmo_nxt;
  logic [1:0]  prod_q, prod_nxt;
  logic [3:0]  stock_news, stock_choc, stock_juice;
  logic        dec_news, dec_choc, dec_juice;

  logic        coin_legal, coin_fits, coin_acc;
  logic [5:0]  coin_sum;
  logic [4:0]  credit_post;
  logic [4:0]  sel_price, vend_price;
  logic [3:0]  sel_stock;

  function automatic logic [4:0] price_of(input logic [1:0] p);
    case (p)
      2'b01:   price_of = P_NEWS;
      2'b10:   price_of = P_CHOC;
      2'b11:   price_of = P_JUICE;
      default: price_of = 5'd0;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      credit  <= 5'd0;
      tmo_cnt <= 5'd0;
      prod_q  <= 2'b00;
    end else begin
      state   <= next_state;
      credit  <= credit_nxt;
      tmo_cnt <= tmo_nxt;
      prod_q  <= prod_nxt;
    end
  end

  // Zero guards keep the counters from wrapping even if a vend slips through.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stock_news  <= STOCK_INIT;
      stock_choc  <= STOCK_INIT;
      stock_juice <= STOCK_INIT;
    end else begin
      if (dec_news && stock_news != 4'd0)
        stock_news <= stock_news - 4'd1;
      if (dec_choc && stock_choc != 4'd0)
        stock_choc <= stock_choc - 4'd1;
      if (dec_juice && stock_juice != 4'd0)
        stock_juice <= stock_juice - 4'd1;
    end
  end

  always_comb begin
    next_state  = state;
    credit_nxt  = credit;
    tmo_nxt     = tmo_cnt;
    prod_nxt    = prod_q;
    dec_news    = 1'b0;
    dec_choc    = 1'b0;
    dec_juice   = 1'b0;
    coin_reject = 1'b0;
    err_valid   = 1'b0;
    err_code    = 2'b00;
    coin_acc    = 1'b0;

    coin_legal  = (coin_value == 5'd5) || (coin_value == 5'd10) ||
                  (coin_value == 5'd20);
    coin_sum    = {1'b0, credit} + {1'b0, coin_value};
    coin_fits   = (coin_sum <= MAX_C);
    credit_post = credit;
    sel_price   = price_of(select_product);
    vend_price  = price_of(prod_q);

    case (select_product)
      2'b01:   sel_stock = stock_news;
      2'b10:   sel_stock = stock_choc;
      2'b11:   sel_stock = stock_juice;
      default: sel_stock = 4'd0;
    endcase

    case (state)
      IDLE, COLLECT: begin
        // Cancel outranks a coin or selection arriving in the same cycle.
        if (coin_valid) begin
          if (cancel || !coin_legal || !coin_fits) begin
            coin_reject = 1'b1;
          end else begin
            coin_acc    = 1'b1;
            credit_post = coin_sum[4:0];
          end
        end

        if (cancel) begin
          if (state == COLLECT) begin
            next_state = CHANGE;
            tmo_nxt    = 5'd0;
          end
        end else begin
          credit_nxt = credit_post;
          if (coin_acc && state == IDLE)
            next_state = COLLECT;

          if (select_valid) begin
            tmo_nxt = 5'd0;
            if (state == IDLE && !coin_acc) begin
              err_valid = 1'b1;
              err_code  = ERR_CREDIT;
            end else if (select_product == 2'b00) begin
              err_valid = 1'b1;
              err_code  = ERR_ILLEGAL;
            end else if (sel_stock == 4'd0) begin
              err_valid = 1'b1;
              err_code  = ERR_SOLDOUT;
            end else if (credit_post < sel_price) begin
              err_valid = 1'b1;
              err_code  = ERR_CREDIT;
            end else begin
              prod_nxt   = select_product;
              next_state = VEND;
            end
          end else if (coin_acc) begin
            tmo_nxt = 5'd0;
          end else if (state == COLLECT) begin
            if (tmo_cnt == TMO_LAST) begin
              next_state = CHANGE;
              tmo_nxt    = 5'd0;
            end else begin
              tmo_nxt = tmo_cnt + 5'd1;
            end
          end
        end
      end

      VEND: begin
        coin_reject = coin_valid;
        if (disp_ack) begin
          credit_nxt = credit - vend_price;
          dec_news   = (prod_q == 2'b01);
          dec_choc   = (prod_q == 2'b10);
          dec_juice  = (prod_q == 2'b11);
          next_state = (credit_nxt != 5'd0) ? CHANGE : IDLE;
        end
      end

      CHANGE: begin
        coin_reject = coin_valid;
        if (credit != 5'd0) begin
          credit_nxt = credit - COIN_UNIT;
          if (credit == COIN_UNIT)
            next_state = IDLE;
        end else begin
          next_state = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

  assign disp_req     = (state == VEND);
  assign disp_product = (state == VEND) ? prod_q : 2'b00;
  assign change_pulse = (state == CHANGE) && (credit != 5'd0);
  assign balance      = credit;
  assign busy         = (state == VEND) || (state == CHANGE);
  assign sold_out     = {stock_juice == 4'd0, stock_choc == 4'd0,
                         stock_news == 4'd0};

endmodule

// File: tb/tb_vend_txn_controller.sv
// Directed bench for vend_txn_controller: per-cycle vector table plus
// hand-written sold-out and asynchronous-reset sequences.
module tb_vend_txn_controller;

  logic       clock, reset;
  logic       coin_valid, select_valid, cancel, disp_ack;
  logic [4:0] coin_value;
  logic [1:0] select_product;
  logic       disp_req, change_pulse, busy, coin_reject, err_valid;
  logic [1:0] disp_product, err_code;
  logic [4:0] balance;
  logic [2:0] sold_out;

  int checks   = 0;
  int failures = 0;

  vend_txn_controller dut (
    .clock          (clock),
    .reset          (reset),
    .coin_valid     (coin_valid),
    .coin_value     (coin_value),
    .select_valid   (select_valid),
    .select_product (select_product),
    .cancel         (cancel),
    .disp_ack       (disp_ack),
    .disp_req       (disp_req),
    .disp_product   (disp_product),
    .change_pulse   (change_pulse),
    .balance        (balance),
    .busy           (busy),
    .coin_reject    (coin_reject),
    .err_valid      (err_valid),
    .err_code       (err_code),
    .sold_out       (sold_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       cv;
    logic [4:0] cval;
    logic       sv;
    logic [1:0] sp;
    logic       cn;
    logic       ack;
    logic       e_req;
    logic [1:0] e_prod;
    logic       e_chg;
    logic [4:0] e_bal;
    logic       e_busy;
    logic       e_crej;
    logic       e_errv;
    logic [1:0] e_errc;
    logic [2:0] e_sold;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic cv, input logic [4:0] cval, input logic sv,
                     input logic [1:0] sp, input logic cn, input logic ack,
                     input logic req, input logic [1:0] prod, input logic chg,
                     input logic [4:0] bal, input logic bsy, input logic crej,
                     input logic errv, input logic [1:0] errc,
                     input logic [2:0] sold);
    vec_t v;
    v.cv = cv; v.cval = cval; v.sv = sv; v.sp = sp; v.cn = cn; v.ack = ack;
    v.e_req = req; v.e_prod = prod; v.e_chg = chg; v.e_bal = bal;
    v.e_busy = bsy; v.e_crej = crej; v.e_errv = errv; v.e_errc = errc;
    v.e_sold = sold;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", nm, idx, act, exp_v);
    end
  endtask

  // One cycle: drive just after the rising edge, sample at the falling edge.
  task automatic cyc(input logic cv, input logic [4:0] cval, input logic sv,
                     input logic [1:0] sp, input logic cn, input logic ack);
    @(posedge clock);
    #1;
    coin_valid = cv; coin_value = cval; select_valid = sv;
    select_product = sp; cancel = cn; disp_ack = ack;
    @(negedge clock);
  endtask

  task automatic idle();
    cyc(0, 5'd0, 0, 2'b00, 0, 0);
  endtask

  initial begin
    coin_valid = 0; coin_value = 0; select_valid = 0;
    select_product = 0; cancel = 0; disp_ack = 0;
    reset = 1'b1;

    // plan 1: chocolate, immediate ack
    add(1,10,0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    add(0, 0,1,2,0,0, 0,0,0,10,0,0,0,0,0);
    add(0, 0,0,0,0,1, 1,2,0,10,1,0,0,0,0);
    add(0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    // plan 2: 20+5, newspaper, ack on third cycle, 4 change pulses
    add(1,20,0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    add(1, 5,0,0,0,0, 0,0,0,20,0,0,0,0,0);
    add(0, 0,1,1,0,0, 0,0,0,25,0,0,0,0,0);
    add(0, 0,0,0,0,0, 1,1,0,25,1,0,0,0,0);
    add(0, 0,0,0,0,0, 1,1,0,25,1,0,0,0,0);
    add(0, 0,0,0,0,1, 1,1,0,25,1,0,0,0,0);
    for (int b = 20; b > 0; b -= 5)
      add(0,0,0,0,0,0, 0,0,1,5'(b),1,0,0,0,0);
    add(0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    // plan 3: insufficient credit, then cancel refund
    add(1, 5,0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    add(0, 0,1,3,0,0, 0,0,0, 5,0,0,1,1,0);
    add(0, 0,0,0,1,0, 0,0,0, 5,0,0,0,0,0);
    add(0, 0,0,0,0,0, 0,0,1, 5,1,0,0,0,0);
    add(0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    // illegal code, cancel priority, coin during CHANGE, IDLE select,
    // same-cycle coin+select from IDLE
    add(1,10,0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    add(0, 0,1,0,0,0, 0,0,0,10,0,0,1,3,0);
    add(1, 5,1,1,1,0, 0,0,0,10,0,1,0,0,0);
    add(0, 0,0,0,0,0, 0,0,1,10,1,0,0,0,0);
    add(1, 5,0,0,0,0, 0,0,1, 5,1,1,0,0,0);
    add(0, 0,1,2,0,0, 0,0,0, 0,0,0,1,1,0);
    add(1, 5,1,1,0,0, 0,0,0, 0,0,0,0,0,0);
    add(0, 0,0,0,0,1, 1,1,0, 5,1,0,0,0,0);
    add(0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    // plan 5: over-limit and illegal coins, then inactivity refund
    add(1,20,0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    add(1,20,0,0,0,0, 0,0,0,20,0,1,0,0,0);
    add(1, 7,0,0,0,0, 0,0,0,20,0,1,0,0,0);
    for (int i = 0; i < 14; i++)
      add(0,0,0,0,0,0, 0,0,0,20,0,0,0,0,0);
    for (int b = 20; b > 0; b -= 5)
      add(0,0,0,0,0,0, 0,0,1,5'(b),1,0,0,0,0);
    add(0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    // credit exactly at the ceiling, then one coin too many
    add(1,20,0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    add(1,10,0,0,0,0, 0,0,0,20,0,0,0,0,0);
    add(1, 5,0,0,0,0, 0,0,0,30,0,1,0,0,0);
    add(0, 0,0,0,1,0, 0,0,0,30,0,0,0,0,0);
    for (int b = 30; b > 0; b -= 5)
      add(0,0,0,0,0,0, 0,0,1,5'(b),1,0,0,0,0);
    add(0, 0,0,0,0,1, 0,0,0, 0,0,0,0,0,0);

    // reset state
    @(negedge clock);
    chk("rst_balance", -1, 32'(balance), 0);
    chk("rst_disp_req", -1, 32'(disp_req), 0);
    chk("rst_busy", -1, 32'(busy), 0);
    chk("rst_change", -1, 32'(change_pulse), 0);
    chk("rst_sold_out", -1, 32'(sold_out), 0);
    @(posedge clock);
    #1 reset = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].cv, vecs[i].cval, vecs[i].sv, vecs[i].sp, vecs[i].cn,
          vecs[i].ack);
      chk("disp_req", i, 32'(disp_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req)
        chk("disp_product", i, 32'(disp_product), 32'(vecs[i].e_prod));
      chk("change_pulse", i, 32'(change_pulse), 32'(vecs[i].e_chg));
      chk("balance", i, 32'(balance), 32'(vecs[i].e_bal));
      chk("busy", i, 32'(busy), 32'(vecs[i].e_busy));
      chk("coin_reject", i, 32'(coin_reject), 32'(vecs[i].e_crej));
      chk("err_valid", i, 32'(err_valid), 32'(vecs[i].e_errv));
      if (vecs[i].e_errv)
        chk("err_code", i, 32'(err_code), 32'(vecs[i].e_errc));
      chk("sold_out", i, 32'(sold_out), 32'(vecs[i].e_sold));
    end

    // plan 4: from fresh stock, three chocolates empty the slot
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cyc(1, 5'd10, 0, 2'b00, 0, 0);
      cyc(0, 5'd0, 1, 2'b10, 0, 0);
      cyc(0, 5'd0, 0, 2'b00, 0, 1);
      chk("so_disp_req", n, 32'(disp_req), 1);
      chk("so_disp_product", n, 32'(disp_product), 2);
      idle();
      chk("so_balance", n, 32'(balance), 0);
    end
    chk("so_sold_out", 3, 32'(sold_out), 32'(3'b010));
    cyc(1, 5'd10, 0, 2'b00, 0, 0);
    cyc(0, 5'd0, 1, 2'b10, 0, 0);
    chk("so_err_valid", 4, 32'(err_valid), 1);
    chk("so_err_code", 4, 32'(err_code), 2);
    chk("so_bal_kept", 4, 32'(balance), 10);
    idle();
    chk("so_no_vend", 5, 32'(disp_req), 0);
    cyc(0, 5'd0, 0, 2'b00, 1, 0);
    idle();
    chk("so_refund", 6, 32'(change_pulse), 1);
    idle();
    chk("so_refund2", 7, 32'(balance), 5);
    idle();
    chk("so_done", 8, 32'(busy), 0);

    // plan 6: asynchronous reset mid-CHANGE
    cyc(1, 5'd20, 0, 2'b00, 0, 0);
    cyc(0, 5'd0, 0, 2'b00, 1, 0);
    idle();
    chk("ar_first_pulse", 0, 32'(change_pulse), 1);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("ar_balance", 1, 32'(balance), 0);
    chk("ar_change", 1, 32'(change_pulse), 0);
    chk("ar_busy", 1, 32'(busy), 0);
    chk("ar_sold_out", 1, 32'(sold_out), 0);
    #2 reset = 1'b0;
    idle();
    chk("ar_after", 2, 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
